// File: rtl/mux_arb_pkg.sv
// Shared constants and helpers for the N-input valid/ready source selector.
package mux_arb_pkg;

   localparam logic MODE_RR    = 1'b0;
   localparam logic MODE_FIXED = 1'b1;

   // Pointer successor with an explicit wrap compare, so any N works.
   function automatic int unsigned next_ptr(input int unsigned g, input int unsigned n);
      if (g + 1 >= n) begin
         return 0;
      end
      return g + 1;
   endfunction

endpackage

// File: rtl/mux_arb_rr_pick.sv
// Round-robin picker: rotate requests by ptr, priority-encode, un-rotate.
module rr_pick #(
   parameter int unsigned N  = 3,
   parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);

   localparam int unsigned SW = IW + 1;

   logic [2*N-1:0] req2;
   logic [N-1:0]   rot;
   logic [IW-1:0]  off;
   logic [SW-1:0]  sum;
   logic           found;

   always_comb begin
      req2  = {req, req};
      rot   = N'(req2 >> ptr);
      off   = '0;
      found = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            off   = IW'(i);
         end
      end
      // Un-rotate: offset from ptr, wrapped by compare rather than overflow.
      sum = SW'(ptr) + SW'(off);
      if (sum >= SW'(N)) begin
         sum = sum - SW'(N);
      end
      idx = found ? IW'(sum) : '0;
      gnt = found ? (N'(1) << idx) : '0;
   end

endmodule

// File: rtl/mux_arb.sv
// N-input WIDTH-bit selector with valid/ready per channel, round-robin or
// fixed-channel arbitration, and a registered single-word output stage.
module mux_arb
   import mux_arb_pkg::*;
#(
   parameter int unsigned N_IN  = 3,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SEL_W = $clog2(N_IN)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      sel,
   input  logic [N_IN-1:0]       in_valid,
   input  logic [N_IN*WIDTH-1:0] in_data,
   output logic [N_IN-1:0]       in_ready,
   output logic                  out_valid,
   output logic [WIDTH-1:0]      out_data,
   output logic [SEL_W-1:0]      out_src,
   input  logic                  out_ready
);

   logic [N_IN-1:0]  rr_gnt;
   logic [SEL_W-1:0] rr_idx;
   logic [N_IN-1:0]  gnt;
   logic [SEL_W-1:0] g_idx;
   logic [N_IN-1:0]  fix_hit;
   logic             can_load;
   logic             xfer;
   logic [WIDTH-1:0] data_sel;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [SEL_W-1:0] out_src_q,   out_src_d;
   logic [SEL_W-1:0] ptr_q,       ptr_d;

   rr_pick #(
      .N  (N_IN),
      .IW (SEL_W)
   ) u_rr_pick (
      .req (in_valid),
      .ptr (ptr_q),
      .gnt (rr_gnt),
      .idx (rr_idx)
   );

   // Grant selection; fixed mode overrides the round-robin result.
   always_comb begin
      gnt     = rr_gnt;
      g_idx   = rr_idx;
      fix_hit = (N_IN'(1) << sel) & in_valid;
      if (mode == MODE_FIXED) begin
         g_idx = sel;
         gnt   = (32'(sel) < N_IN) ? fix_hit : '0;
      end
   end

   // Accept while the output is empty or draining; nothing accepted in reset.
   always_comb begin
      can_load = ~out_valid_q | out_ready;
      in_ready = gnt & {N_IN{can_load & rst_n}};
      xfer     = |in_ready;
   end

   always_comb begin
      data_sel = '0;
      for (int i = 0; i < int'(N_IN); i++) begin
         if (gnt[i]) begin
            data_sel = data_sel | in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      ptr_d       = ptr_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = data_sel;
         out_src_d   = g_idx;
         if (mode == MODE_RR) begin
            ptr_d = SEL_W'(next_ptr(32'(g_idx), N_IN));
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux_arb.sv
// Scoreboard bench for mux_arb: a queue-based model predicts grants and words,
// an independent monitor checks every word the DUT presents.
module tb_mux_arb;

   localparam int unsigned N = 3;
   localparam int unsigned W = 32;

   logic           clk;
   logic           rst_n;
   logic           mode;
   logic [1:0]     sel;
   logic [N-1:0]   in_valid;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic [1:0]     out_src;
   logic           out_ready;

   mux_arb #(.N_IN(N), .WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready)
   );

   typedef struct {
      logic [W-1:0] d;
      int           s;
   } item_t;

   item_t        sbq[$];
   logic [W-1:0] dat[N];
   int           m_ptr;
   bit           m_valid;
   int           errors;
   int           checks;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Arbitration rule from the channel list: fixed channel, or first valid from ptr.
   function automatic int model_grant(input logic m, input logic [1:0] s, input logic [N-1:0] v);
      if (m) begin
         if (s < N && v[s]) return int'(s);
         return -1;
      end
      for (int k = 0; k < int'(N); k++) begin
         int c;
         c = (m_ptr + k) % N;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   task automatic cyc(input logic m, input logic [1:0] s, input logic [N-1:0] v, input logic ordy);
      int           g;
      logic [N-1:0] er;
      @(negedge clk);
      mode      = m;
      sel       = s;
      in_valid  = v;
      out_ready = ordy;
      in_data   = {dat[2], dat[1], dat[0]};
      #1;
      chk("out_valid", longint'(out_valid), longint'(m_valid));
      g  = model_grant(m, s, v);
      er = (g >= 0 && (!m_valid || ordy)) ? N'(1 << g) : '0;
      chk("in_ready", longint'(in_ready), longint'(er));
      if (er != '0) begin
         sbq.push_back('{dat[g], g});
         m_valid = 1'b1;
         if (m == 1'b0) m_ptr = (g + 1) % N;
      end else if (ordy) begin
         m_valid = 1'b0;
      end
   endtask

   // Monitor: held word must match the oldest expected word; pop on drain.
   always begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid) begin
         if (sbq.size() == 0) begin
            chk("unexpected_word", longint'(out_data), -1);
         end else begin
            chk("out_data", longint'(out_data), longint'(sbq[0].d));
            chk("out_src", longint'(out_src), longint'(sbq[0].s));
            if (out_ready) void'(sbq.pop_front());
         end
      end
   end

   initial begin
      errors    = 0;
      checks    = 0;
      m_ptr     = 0;
      m_valid   = 1'b0;
      rst_n     = 1'b0;
      mode      = 1'b0;
      sel       = '0;
      in_valid  = 3'b111;
      out_ready = 1'b1;
      dat[0] = 32'd1; dat[1] = 32'd2; dat[2] = 32'd3;
      in_data = {dat[2], dat[1], dat[0]};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_out_data", longint'(out_data), 0);
      chk("rst_out_src", longint'(out_src), 0);
      chk("rst_in_ready", longint'(in_ready), 0);
      @(negedge clk);
      in_valid = '0;
      #1 rst_n = 1'b1;

      // Round-robin fairness over three always-valid channels
      repeat (7) cyc(1'b0, 2'd0, 3'b111, 1'b1);
      // Fixed select, then an out-of-range select drains the output
      repeat (4) cyc(1'b1, 2'd2, 3'b111, 1'b1);
      repeat (3) cyc(1'b1, 2'd3, 3'b111, 1'b1);
      // Back-pressure on word 2, then refill while draining
      cyc(1'b1, 2'd1, 3'b111, 1'b1);
      repeat (4) cyc(1'b0, 2'd0, 3'b111, 1'b0);
      cyc(1'b0, 2'd0, 3'b111, 1'b1);
      // Skip and wrap from ptr=2 with channel 2 idle
      repeat (2) cyc(1'b0, 2'd0, 3'b011, 1'b1);
      cyc(1'b0, 2'd0, 3'b000, 1'b1);

      // Mid-operation reset with a held word
      cyc(1'b0, 2'd0, 3'b110, 1'b0);
      @(negedge clk);
      out_ready = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", longint'(out_valid), 0);
      chk("midrst_in_ready", longint'(in_ready), 0);
      sbq.delete();
      m_valid = 1'b0;
      m_ptr   = 0;
      @(negedge clk);
      in_valid = '0;
      #3 rst_n = 1'b1;
      cyc(1'b0, 2'd0, 3'b110, 1'b1);
      cyc(1'b0, 2'd0, 3'b000, 1'b1);

      // Randomised traffic
      for (int t = 0; t < 400; t++) begin
         for (int i = 0; i < int'(N); i++) dat[i] = $urandom;
         cyc(($urandom % 4) == 0, 2'($urandom % 4), N'($urandom), ($urandom % 3) != 0);
      end

      repeat (6) cyc(1'b0, 2'd0, 3'b000, 1'b1);
      chk("queue_drained", longint'(sbq.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
